// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM DAC control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_pkg;

    // Default DAC sample width per rail (real and imag each).
    localparam int DATA_W = 14;

    // Avalon-MM control register word addresses.
    localparam logic [1:0] ADDR_CTRL         = 2'd0;
    localparam logic [1:0] ADDR_RATE_DIV     = 2'd1;
    localparam logic [1:0] ADDR_STATUS       = 2'd2;
    localparam logic [1:0] ADDR_UNDERRUN_CNT = 2'd3;

    // Encoding is software-visible through STATUS[9:8].
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFILL  = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_e;

endpackage

// File: rtl/ofdm_sample_fifo.sv
// Synchronous show-ahead sample FIFO with an occupancy count.
// Latency: a pushed word is visible on head the cycle after the push if the FIFO was empty.
// Backpressure: full is exported; pushes while full and pops while empty are ignored.
// Ports: clk/rst_n clock and async active-low reset; flush empties the FIFO synchronously;
//        push/push_data write side; pop/head read side; fill 0..DEPTH; full.
module ofdm_sample_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Guards keep the count consistent even if the caller misbehaves;
    // a pop on an empty FIFO never consumes a word pushed in the same cycle.
    assign full    = (fill == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (fill != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/ofdm_dac_control.sv
// OFDM DAC control: buffers Avalon-ST IQ samples and paces them onto a registered DAC conduit.
// Latency: popped sample on dac_* one cycle after its strobe; avs_readdata one cycle after avs_read.
// Backpressure: asi_ready = ENABLE and FIFO not full; the DAC side never stalls, an empty FIFO on strobe is an underrun.
// Ports: clk_clk/reset_reset_n clock and async active-low reset; asi_* sample sink ({real, imag});
//        avs_* control slave (CTRL, RATE_DIV, STATUS, UNDERRUN_CNT); dac_RealData/dac_ImagData DAC outputs.
module ofdm_dac_control #(
    parameter int DATA_W     = ofdm_pkg::DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [2*DATA_W-1:0]   asi_data,
    input  logic                  asi_valid,
    output logic                  asi_ready,
    input  logic [1:0]            avs_address,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    input  logic                  avs_read,
    output logic [31:0]           avs_readdata,
    output logic [DATA_W-1:0]     dac_RealData,
    output logic [DATA_W-1:0]     dac_ImagData
);
    import ofdm_pkg::*;

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_e               state;
    state_e               state_nxt;
    logic                 enable;
    logic [15:0]          rate_div;
    logic [15:0]          div_cnt;
    logic [15:0]          underrun_cnt;
    logic [FW-1:0]        fill;
    logic                 fifo_full;
    logic [2*DATA_W-1:0]  head;
    logic [31:0]          status_word;
    logic                 wr_ctrl;
    logic                 wr_rate;
    logic                 clr_underrun;
    logic                 strobe;
    logic                 push;
    logic                 pop;
    logic                 underrun_evt;
    logic                 div_hold;
    logic                 unused_wdata;

    assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
    assign wr_rate      = avs_write && (avs_address == ADDR_RATE_DIV);
    assign clr_underrun = wr_ctrl && avs_writedata[1];
    assign strobe       = (div_cnt == rate_div);
    assign asi_ready    = enable && !fifo_full;
    assign push         = asi_valid && asi_ready;
    assign unused_wdata = ^avs_writedata[31:16];

    ofdm_sample_fifo #(
        .W     (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (!enable),
        .push      (push),
        .push_data (asi_data),
        .pop       (pop),
        .head      (head),
        .fill      (fill),
        .full      (fifo_full)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = ST_PREFILL;
                ST_PREFILL:  if (fill >= FW'(PREFILL)) state_nxt = ST_RUN;
                ST_RUN:      if (strobe && (fill == '0)) state_nxt = ST_UNDERRUN;
                ST_UNDERRUN: state_nxt = ST_PREFILL;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pops and underruns are gated by ENABLE so a disable never lets a
    // last sample slip out while the FIFO is being flushed.
    always_comb begin
        pop          = 1'b0;
        underrun_evt = 1'b0;
        div_hold     = 1'b1;
        case (state)
            ST_RUN: begin
                pop          = enable && strobe && (fill != '0);
                underrun_evt = enable && strobe && (fill == '0);
                div_hold     = 1'b0;
            end
            ST_PREFILL, ST_UNDERRUN: div_hold = 1'b0;
            default: ;
        endcase
    end

    // ---------------- Sample-rate divider ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_cnt <= '0;
        end else if (div_hold || wr_rate || strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // ---------------- Control registers ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            enable       <= 1'b0;
            rate_div     <= '0;
            underrun_cnt <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= avs_writedata[0];
            end
            if (wr_rate) begin
                rate_div <= avs_writedata[15:0];
            end
            // Software clear wins over a coincident underrun.
            if (clr_underrun) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[4:0] = 5'(fill);
        status_word[9:8] = state;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:     avs_readdata <= {31'd0, enable};
                ADDR_RATE_DIV: avs_readdata <= {16'd0, rate_div};
                ADDR_STATUS:   avs_readdata <= status_word;
                default:       avs_readdata <= {16'd0, underrun_cnt};
            endcase
        end
    end

    // ---------------- DAC conduit ----------------
    // Holds the last sample between strobes; forced to zero on disable or underrun.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            dac_RealData <= '0;
            dac_ImagData <= '0;
        end else if (!enable || underrun_evt) begin
            dac_RealData <= '0;
            dac_ImagData <= '0;
        end else if (pop) begin
            dac_RealData <= head[2*DATA_W-1:DATA_W];
            dac_ImagData <= head[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_ofdm_dac_control.sv
`timescale 1ns/1ps
module tb_ofdm_dac_control;
    import ofdm_pkg::*;

    localparam int DW = 14;
    localparam int SW = 2*DW;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [SW-1:0] asi_data;
    logic          asi_valid;
    logic          asi_ready;
    logic          asi_ready16;
    logic [1:0]    avs_address;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic          avs_read;
    logic [31:0]   avs_readdata;
    logic [31:0]   avs_readdata16;
    logic [DW-1:0] dac_RealData;
    logic [DW-1:0] dac_ImagData;
    logic [DW-1:0] dac_real16;
    logic [DW-1:0] dac_imag16;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [SW-1:0] q[$];   // samples accepted by the DUT, oldest first

    always #5 clk_clk = ~clk_clk;

    ofdm_dac_control #(.DATA_W(DW), .FIFO_DEPTH(16), .PREFILL(8)) u_dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .dac_RealData(dac_RealData), .dac_ImagData(dac_ImagData)
    );

    // Same stimulus, but it only leaves PREFILL once completely full.
    ofdm_dac_control #(.DATA_W(DW), .FIFO_DEPTH(16), .PREFILL(16)) u_dut16 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready16),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata16),
        .dac_RealData(dac_real16), .dac_ImagData(dac_imag16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    function automatic logic [31:0] dac_word();
        return 32'({dac_RealData, dac_ImagData});
    endfunction

    // Eight back-to-back pushes; directed samples are real=n, imag=-n.
    task automatic push_samples(input bit directed);
        for (int i = 1; i <= 8; i++) begin
            logic [DW-1:0] re;
            logic [DW-1:0] im;
            if (directed) begin
                re = DW'(i);
                im = DW'(-i);
            end else begin
                re = DW'($urandom_range(1, (1 << DW) - 1));
                im = DW'($urandom);
            end
            asi_data  = {re, im};
            asi_valid = 1'b1;
            check("asi_ready_push", {31'd0, asi_ready}, 32'd1);
            step();
            q.push_back({re, im});
        end
        asi_valid = 1'b0;
    endtask

    // Waits (bounded) for the DAC to leave zero; every test sample has a nonzero real part.
    task automatic wait_first();
        int t = 0;
        while (dac_word() == 32'd0 && t < 200) begin
            step();
            t++;
        end
        check("first_out_seen", {31'd0, (t < 200)}, 32'd1);
    endtask

    // Expected: samples leave in push order, one every r+1 cycles, then an
    // underrun zeroes the DAC on the next strobe and the counter moves.
    task automatic run_check(input int r, input bit clr);
        logic [31:0] d;
        logic [SW-1:0] s;
        wait_first();
        for (int k = 0; k < 8; k++) begin
            s = q.pop_front();
            for (int c = 0; c <= r; c++) begin
                check("dac_sample", dac_word(), 32'(s));
                if (clr && k == 7 && c == r) begin
                    avs_address   = ADDR_CTRL;
                    avs_writedata = 32'h3;
                    avs_write     = 1'b1;
                end
                step();
            end
        end
        avs_write = 1'b0;
        check("dac_underrun_zero", dac_word(), 32'd0);
        exp_cnt = clr ? 0 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
        csr_read(ADDR_UNDERRUN_CNT, d);
        check("underrun_cnt", d, 32'(exp_cnt));
        csr_read(ADDR_STATUS, d);
        check("status_after_underrun", d, 32'h100);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int pushes16;
        int t;

        reset_reset_n = 1'b0;
        asi_data      = '0;
        asi_valid     = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        #23;
        check("rst_asi_ready", {31'd0, asi_ready}, 32'd0);
        check("rst_dac", dac_word(), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset_reset_n = 1'b1;
        step();
        csr_read(ADDR_CTRL, d);         check("rst_ctrl", d, 32'd0);
        csr_read(ADDR_RATE_DIV, d);     check("rst_rate_div", d, 32'd0);
        csr_read(ADDR_STATUS, d);       check("rst_status", d, 32'd0);
        csr_read(ADDR_UNDERRUN_CNT, d); check("rst_underrun_cnt", d, 32'd0);

        // Full-FIFO backpressure on the PREFILL=16 instance.
        csr_write(ADDR_RATE_DIV, 32'd5);
        csr_write(ADDR_CTRL, 32'd1);
        asi_valid = 1'b1;
        pushes16  = 0;
        t         = 0;
        while (t < 40) begin
            if (asi_ready16) pushes16++;
            asi_data = SW'($urandom);
            step();
            t++;
            if (!asi_ready16) break;
        end
        asi_valid = 1'b0;
        check("full_pushes", 32'(pushes16), 32'd16);
        check("full_ready_low", {31'd0, asi_ready16}, 32'd0);
        csr_read(ADDR_STATUS, d);
        check("full_fill", {27'd0, avs_readdata16[4:0]}, 32'd16);

        // Disable plus counter clear returns the main instance to a clean IDLE.
        csr_write(ADDR_CTRL, 32'h2);
        step();
        check("dis_dac", dac_word(), 32'd0);
        check("dis_ready", {31'd0, asi_ready}, 32'd0);
        csr_read(ADDR_STATUS, d);
        check("dis_status", d, 32'd0);
        exp_cnt = 0;

        // Directed stream n=1..8 at RATE_DIV=3, then underrun.
        csr_write(ADDR_RATE_DIV, 32'd3);
        csr_write(ADDR_CTRL, 32'd1);
        q.delete();
        push_samples(1'b1);
        run_check(3, 1'b0);

        // Randomized rates and samples.
        for (int trial = 0; trial < 2; trial++) begin
            int r;
            r = $urandom_range(0, 5);
            csr_write(ADDR_RATE_DIV, 32'(r));
            push_samples(1'b0);
            run_check(r, 1'b0);
        end
        check("cnt_model_at_3", 32'(exp_cnt), 32'd3);

        // Clear lands on the underrun cycle with the counter at 3.
        csr_write(ADDR_RATE_DIV, 32'd3);
        push_samples(1'b0);
        run_check(3, 1'b1);

        // Disable during RUN with five samples still buffered.
        push_samples(1'b1);
        wait_first();
        check("r31_first", dac_word(), 32'(q[0]));
        repeat (8) step();
        check("r31_third", dac_word(), 32'(q[2]));
        csr_read(ADDR_STATUS, d);
        check("r31_status_run", d, 32'h205);
        csr_write(ADDR_CTRL, 32'd0);
        step();
        check("r31_dac", dac_word(), 32'd0);
        check("r31_ready", {31'd0, asi_ready}, 32'd0);
        csr_read(ADDR_STATUS, d);
        check("r31_status_idle", d, 32'd0);
        q.delete();

        // Asynchronous reset in the middle of RUN.
        csr_write(ADDR_RATE_DIV, 32'd3);
        csr_write(ADDR_CTRL, 32'd1);
        push_samples(1'b0);
        wait_first();
        check("r32_first", dac_word(), 32'(q[0]));
        csr_read(ADDR_RATE_DIV, d);
        check("r32_rate", d, 32'd3);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("r32_async_dac", dac_word(), 32'd0);
        check("r32_async_ready", {31'd0, asi_ready}, 32'd0);
        check("r32_async_readdata", avs_readdata, 32'd0);
        step();
        reset_reset_n = 1'b1;
        step();
        q.delete();
        exp_cnt = 0;
        csr_write(ADDR_RATE_DIV, 32'd3);
        csr_write(ADDR_CTRL, 32'd1);
        repeat (6) step();
        check("r32_quiet", dac_word(), 32'd0);
        push_samples(1'b0);
        run_check(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
